// File: rtl/button_press_classifier.sv
// button_press_classifier
// Turns the debounced, Clk-synchronous button level into single-cycle gesture
// pulses: Press, Release, ShortPress, LongPress and DoubleClick. Held mirrors
// the registered level.
// Optional feature: define PRESS_AUTOREPEAT_EN to add the Repeat output, which
// pulses every REPEAT_COUNT cycles while the button stays in a long press.
// The input already comes from the debouncer in the Clk domain, so there is no
// synchroniser here.

module button_press_classifier #(
  parameter int CNT_W        = 26,
  parameter int LONG_COUNT   = 25000000,
  parameter int GAP_COUNT    = 12500000,
  parameter int REPEAT_COUNT = 5000000
) (
  input  logic Clk,
  input  logic nReset,
  input  logic Level,
  output logic Press,
  output logic Release,
  output logic ShortPress,
  output logic LongPress,
  output logic DoubleClick,
  output logic Held
`ifdef PRESS_AUTOREPEAT_EN
  ,
  output logic Repeat
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HELD  = 3'd1,
    GAP   = 3'd2,
    HELD2 = 3'd3,
    LONG  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_q;
  logic             rise;
  logic             fall;

  assign rise     = Level & ~level_q;
  assign fall     = ~Level & level_q;
  assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign Held     = level_q;

`ifdef PRESS_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_COUNT - 1);
  logic [CNT_W-1:0] rep_cnt;
`endif

  // Gesture FSM: edge register, dwell counter and registered event pulses.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      cnt         <= '0;
      level_q     <= 1'b0;
      Press       <= 1'b0;
      Release     <= 1'b0;
      ShortPress  <= 1'b0;
      LongPress   <= 1'b0;
      DoubleClick <= 1'b0;
`ifdef PRESS_AUTOREPEAT_EN
      rep_cnt     <= '0;
      Repeat      <= 1'b0;
`endif
    end else begin
      level_q     <= Level;
      Press       <= 1'b0;
      Release     <= 1'b0;
      ShortPress  <= 1'b0;
      LongPress   <= 1'b0;
      DoubleClick <= 1'b0;
`ifdef PRESS_AUTOREPEAT_EN
      Repeat      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise) begin
            Press <= 1'b1;
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt_next;
          end
        end
        HELD: begin
          if (fall) begin
            Release <= 1'b1;
            state   <= GAP;
            cnt     <= '0;
          end else if (cnt == LONG_LIM) begin
            LongPress <= 1'b1;
            state     <= LONG;
            cnt       <= '0;
`ifdef PRESS_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
          end else begin
            cnt <= cnt_next;
          end
        end
        GAP: begin
          if (rise) begin
            Press       <= 1'b1;
            DoubleClick <= 1'b1;
            state       <= HELD2;
            cnt         <= '0;
          end else if (cnt == GAP_LIM) begin
            ShortPress <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
          end else begin
            cnt <= cnt_next;
          end
        end
        HELD2: begin
          if (fall) begin
            Release <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt_next;
          end
        end
        LONG: begin
          if (fall) begin
            Release <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt_next;
`ifdef PRESS_AUTOREPEAT_EN
            if (rep_cnt == REP_LIM) begin
              Repeat  <= 1'b1;
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
`endif
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// tb_button_press_classifier
// Directed gestures with hand-computed event cycles. Stimulus pushes the
// expected pulse vector and cycle into a queue; the monitor pops one entry
// whenever the DUT shows any pulse and compares it. Define PRESS_AUTOREPEAT_EN
// to also exercise the Repeat output.

module tb_button_press_classifier;

  localparam logic [5:0] P_PRESS  = 6'b100000;
  localparam logic [5:0] P_REL    = 6'b010000;
  localparam logic [5:0] P_SHORT  = 6'b001000;
  localparam logic [5:0] P_LONG   = 6'b000100;
  localparam logic [5:0] P_DOUBLE = 6'b000010;
  localparam logic [5:0] P_REPEAT = 6'b000001;

  typedef struct {
    int         cyc;
    logic [5:0] pulses;
  } ev_t;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  logic Level = 1'b0;
  logic Press, Release, ShortPress, LongPress, DoubleClick, Held;
  logic rep;
  logic [5:0] got;
  logic held_exp;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;
  ev_t exp_q[$];

`ifdef PRESS_AUTOREPEAT_EN
  logic Repeat;
  assign rep = Repeat;
`else
  assign rep = 1'b0;
`endif

  assign got = {Press, Release, ShortPress, LongPress, DoubleClick, rep};

  button_press_classifier #(
    .CNT_W       (8),
    .LONG_COUNT  (20),
    .GAP_COUNT   (10),
    .REPEAT_COUNT(5)
  ) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .Level      (Level),
    .Press      (Press),
    .Release    (Release),
    .ShortPress (ShortPress),
    .LongPress  (LongPress),
    .DoubleClick(DoubleClick),
    .Held       (Held)
`ifdef PRESS_AUTOREPEAT_EN
    ,
    .Repeat     (Repeat)
`endif
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  // Edge counter used to timestamp expected and observed pulses.
  always @(posedge Clk) cyc <= cyc + 1;

  // Expected Held: the level as sampled at the previous rising edge.
  always @(posedge Clk or negedge nReset) begin
    if (!nReset) held_exp <= 1'b0;
    else         held_exp <= Level;
  end

  // Monitor: compares every presented pulse against the scoreboard head.
  always @(negedge Clk) begin
    ev_t ev;
    if (done) begin
      checks = checks + 1;
      if (exp_q.size() != 0) begin
        errors = errors + 1;
        $display("[TB] FAIL leftover: %0d expected events never seen, next cyc %0d pulses %b",
                 exp_q.size(), exp_q[0].cyc, exp_q[0].pulses);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (!nReset) begin
      checks = checks + 1;
      if (got != 6'b0 || Held != 1'b0) begin
        errors = errors + 1;
        $display("[TB] FAIL reset_state cyc %0d: pulses=%b Held=%b, required 000000 and 0",
                 cyc, got, Held);
      end
    end else begin
      checks = checks + 1;
      if (Held != held_exp) begin
        errors = errors + 1;
        $display("[TB] FAIL held cyc %0d: Held=%b, required %b", cyc, Held, held_exp);
      end
      if (got != 6'b0) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("[TB] FAIL unexpected_event cyc %0d: pulses=%b, required none", cyc, got);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.pulses != got) begin
            errors = errors + 1;
            $display("[TB] FAIL event: got pulses=%b at cyc %0d, required %b at cyc %0d",
                     got, cyc, ev.pulses, ev.cyc);
          end
        end
      end
    end
  end

  // Safety net in case the stimulus never completes.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d checks=%0d",
             errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expect_event(input int c, input logic [5:0] v);
    ev_t ev;
    ev.cyc    = c;
    ev.pulses = v;
    exp_q.push_back(ev);
  endtask

  // Drives high for h1, low for l1, then optionally high h2 and low l2 cycles.
  // A rise is seen at the edge following the first negedge, i.e. cyc+1.
  task automatic apply_stimulus(input int h1, input int l1, input int h2, input int l2);
    Level = 1'b1;
    repeat (h1) @(negedge Clk);
    Level = 1'b0;
    repeat (l1) @(negedge Clk);
    if (h2 > 0) begin
      Level = 1'b1;
      repeat (h2) @(negedge Clk);
      Level = 1'b0;
      repeat (l2) @(negedge Clk);
    end
  endtask

  initial begin
    int e;
    $display("[TB] start");
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    repeat (3) @(negedge Clk);

    // Single short press.
    e = cyc + 1;
    expect_event(e,      P_PRESS);
    expect_event(e + 5,  P_REL);
    expect_event(e + 15, P_SHORT);
    apply_stimulus(5, 20, 0, 0);

    // Long press.
    e = cyc + 1;
    expect_event(e,      P_PRESS);
    expect_event(e + 20, P_LONG);
    expect_event(e + 30, P_REL);
    apply_stimulus(30, 5, 0, 0);

    // Double click.
    e = cyc + 1;
    expect_event(e,      P_PRESS);
    expect_event(e + 3,  P_REL);
    expect_event(e + 7,  P_PRESS | P_DOUBLE);
    expect_event(e + 10, P_REL);
    apply_stimulus(3, 4, 3, 5);

    // Fall exactly when the long-press limit would hit: release wins.
    e = cyc + 1;
    expect_event(e,      P_PRESS);
    expect_event(e + 20, P_REL);
    expect_event(e + 30, P_SHORT);
    apply_stimulus(20, 15, 0, 0);

    // Rise exactly when the gap limit would hit: double click wins.
    e = cyc + 1;
    expect_event(e,      P_PRESS);
    expect_event(e + 2,  P_REL);
    expect_event(e + 12, P_PRESS | P_DOUBLE);
    expect_event(e + 14, P_REL);
    apply_stimulus(2, 10, 2, 15);

    // One cycle too late for a double click: short press, then a fresh press.
    e = cyc + 1;
    expect_event(e,      P_PRESS);
    expect_event(e + 2,  P_REL);
    expect_event(e + 12, P_SHORT);
    expect_event(e + 13, P_PRESS);
    expect_event(e + 15, P_REL);
    expect_event(e + 25, P_SHORT);
    apply_stimulus(2, 11, 2, 15);

`ifdef PRESS_AUTOREPEAT_EN
    // Auto-repeat during a long hold; release suppresses the coincident repeat.
    e = cyc + 1;
    expect_event(e,      P_PRESS);
    expect_event(e + 20, P_LONG);
    expect_event(e + 25, P_REPEAT);
    expect_event(e + 30, P_REPEAT);
    expect_event(e + 35, P_REPEAT);
    expect_event(e + 40, P_REL);
    apply_stimulus(40, 5, 0, 0);
`endif

    // Reset in the middle of a hold aborts silently.
    e = cyc + 1;
    expect_event(e, P_PRESS);
    Level = 1'b1;
    repeat (3) @(negedge Clk);
    @(posedge Clk);
    #3;
    nReset = 1'b0;
    repeat (2) @(negedge Clk);
    // Level still high at release: the first sampled edge is a rise.
    nReset = 1'b1;
    e = cyc + 1;
    expect_event(e,      P_PRESS);
    expect_event(e + 3,  P_REL);
    expect_event(e + 13, P_SHORT);
    repeat (3) @(negedge Clk);
    Level = 1'b0;
    repeat (20) @(negedge Clk);

    done = 1'b1;
    repeat (3) @(negedge Clk);
  end

endmodule

// File: doc/button_press_classifier.md
Name: button_press_classifier

Overview:
- Sits directly downstream of the button debouncer; consumes its clean, Clk-synchronous level and classifies user gestures.
- Emits single-cycle event pulses for press, release, short press, long press and double click.
- Control FSMs consume these pulses instead of raw levels.
- Input is already registered in the Clk domain, so the block has no synchroniser.

Parameters:
- CNT_W, 26, counter width in bits.
- LONG_COUNT, 25000000, cycles held before LongPress fires (0.5 s at 50 MHz).
- GAP_COUNT, 12500000, maximum release-to-second-press gap for DoubleClick, in cycles.
- REPEAT_COUNT, 5000000, auto-repeat period in cycles (used only with the optional feature).

Ports:
- Clk  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- Level  in  1  debounced button level from the debouncer, 1 = pressed.
- Press  out  1  one-cycle pulse on every press edge.
- Release  out  1  one-cycle pulse on every release edge.
- ShortPress  out  1  one-cycle pulse: single press released before LONG_COUNT, with no second press within GAP_COUNT.
- LongPress  out  1  one-cycle pulse: press held LONG_COUNT cycles.
- DoubleClick  out  1  one-cycle pulse: second press within GAP_COUNT of a short release.
- Held  out  1  registered copy of Level (Level_q).

Behaviour:
- Reset (async assert, sync release): state=IDLE, Cnt=0, Level_q=0, all outputs 0.
  - Reset mid-gesture aborts it silently; no pulse is emitted.
  - If Level=1 when reset releases, the first sampled edge is a rise, so Press follows.
- Edge detect:
  - rise = Level & ~Level_q; fall = ~Level & Level_q.
  - Level_q <= Level every cycle.
- All outputs are registered. A pulse is high for exactly one cycle, on the cycle after the clock edge at which its triggering condition is evaluated true.
- Cnt has CNT_W bits, is cleared on every state change, increments by 1 otherwise, and saturates at all-ones (never wraps).
- States:
  - IDLE: on rise -> Press, go HELD.
  - HELD:
    - fall -> Release, go GAP.
    - else if Cnt==LONG_COUNT-1 -> LongPress, go LONG.
    - Fall takes priority over the limit in the same cycle; no LongPress is emitted.
  - GAP:
    - rise -> Press and DoubleClick in the same cycle, go HELD2.
    - else if Cnt==GAP_COUNT-1 -> ShortPress, go IDLE.
    - Rise takes priority over the limit; no ShortPress is emitted.
  - HELD2: fall -> Release, go IDLE. There is no long-press detection on the second press.
  - LONG: fall -> Release, go IDLE.
- ShortPress and DoubleClick are mutually exclusive per gesture. Exactly one of ShortPress, LongPress or DoubleClick fires per completed gesture.
- Only one Level transition can occur per cycle, so rise and fall never coincide.
- Unused state encodings recover to IDLE on the next cycle with no pulses.
- Parameter legality: LONG_COUNT, GAP_COUNT and REPEAT_COUNT are each ≥2 and < 2^CNT_W.

Optional Feature:
- Macro: PRESS_AUTOREPEAT_EN.
- Defined:
  - Adds output Repeat (out, 1).
  - In LONG, Repeat pulses one cycle every REPEAT_COUNT cycles while held. The first pulse comes REPEAT_COUNT cycles after LongPress.
  - A separate repeat counter is cleared on entry to LONG and on each Repeat pulse.
  - On fall, no Repeat is emitted in the same cycle as Release.
- Undefined: no Repeat port, no repeat counter; LONG waits only for fall.

Test Plan (CNT_W=8, LONG_COUNT=20, GAP_COUNT=10, REPEAT_COUNT=5):
1. Reset, Level high for 5 cycles then low, idle 15 cycles:
   - Press at cycle 1, Release at cycle 6.
   - ShortPress exactly 10 cycles after GAP entry.
   - No LongPress, no DoubleClick.
2. Level high for 30 cycles:
   - Press, then LongPress exactly 20 cycles after HELD entry.
   - Release on fall.
   - No ShortPress.
3. Level high 3, low 4, high 3, low:
   - Press, Release, then Press and DoubleClick in the same cycle, then Release.
   - No ShortPress.
4. Boundaries:
   - Fall on the cycle where HELD Cnt==19 -> Release only, no LongPress.
   - Rise on the cycle where GAP Cnt==9 -> DoubleClick, no ShortPress.
5. Reset:
   - Assert nReset mid-HELD -> all outputs 0 immediately.
   - Release reset with Level=1 -> Press one cycle after the first sampling edge.
6. Auto-repeat (PRESS_AUTOREPEAT_EN defined), hold 40 cycles:
   - LongPress at 20, then Repeat at +5, +10, +15 ...
   - Release emitted with no coincident Repeat.
